// File: rtl/serial_rr_scheduler_if.sv
// Requester-side and serial-link-side signals of serial_rr_scheduler, grouped into one bundle.
// The scheduler connects through the slave modport; producers and the link sink use master.
interface serial_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      serial_o;
  logic                      valid_o;
  logic [IDX_W-1:0]          src_o;
  logic                      last_o;
  logic                      empty_o;

  modport slave (
    input  req_i, data_i,
    output gnt_o, serial_o, valid_o, src_o, last_o, empty_o
  );

  modport master (
    output req_i, data_i,
    input  gnt_o, serial_o, valid_o, src_o, last_o, empty_o
  );
endinterface

// File: rtl/serial_rr_scheduler.sv
// Round-robin arbiter feeding one LSB-first parallel-to-serial engine shared by NUM_REQ requesters.
// Optional feature macro: SERIAL_PARITY_EN appends an even-parity bit to every frame.
module serial_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_rr_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
`ifdef SERIAL_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     src_q, src_d;
  logic                 serial_q, valid_q, last_q, empty_q;

  logic                 last_bit_s, win_open_s, found_s, grant_s;
  logic [IDX_W-1:0]     cand_s, win_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic [DATA_W-1:0]    words_s [NUM_REQ];
  logic [DATA_W-1:0]    word_s;
  logic [FRAME_LEN-1:0] frame_s;

`ifdef SERIAL_PARITY_EN
  function automatic logic parity_f(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  assign last_bit_s = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign win_open_s = (state_q == ST_IDLE) || last_bit_s;
  assign grant_s    = |gnt_s;

  // Unpack the flat data bus into one word per requester.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      words_s[k] = bus.data_i[k*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting just after the last winner; grants are held off while in reset.
  always_comb begin
    gnt_s   = '0;
    win_s   = '0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found_s && bus.req_i[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    if (win_open_s && found_s && !reset) begin
      gnt_s[win_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  assign word_s = words_s[win_s];
`ifdef SERIAL_PARITY_EN
  assign frame_s = {parity_f(word_s), word_s};
`else
  assign frame_s = word_s;
`endif

  // Next-state: a grant always (re)loads the engine, even on the last bit of a running frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    if (grant_s) begin
      state_d = ST_SHIFT;
      shreg_d = frame_s;
      cnt_d   = '0;
      ptr_d   = win_s;
      src_d   = win_s;
    end else if (state_q == ST_SHIFT) begin
      if (last_bit_s) begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  // State and registered link outputs, the latter derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      src_q    <= '0;
      serial_q <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      src_q    <= src_d;
      serial_q <= (state_d == ST_SHIFT) & shreg_d[0];
      valid_q  <= (state_d == ST_SHIFT);
      last_q   <= (state_d == ST_SHIFT) && (cnt_d == CNT_W'(FRAME_LEN - 1));
      empty_q  <= (state_d != ST_SHIFT);
    end
  end

  assign bus.gnt_o    = gnt_s;
  assign bus.serial_o = serial_q;
  assign bus.valid_o  = valid_q;
  assign bus.src_o    = src_q;
  assign bus.last_o   = last_q;
  assign bus.empty_o  = empty_q;

endmodule

// File: tb/tb_serial_rr_scheduler.sv
// Directed bench for serial_rr_scheduler: a round-robin model pushes expected frame bits to a
// scoreboard queue when a grant is predicted; each cycle the front entry is compared to the link.
module tb_serial_rr_scheduler;
`ifdef SERIAL_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  typedef struct {
    logic       bit_v;
    logic [1:0] src;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(4)) bus ();

  serial_rr_scheduler #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         gnt_log[$];
  logic       bit_log[$];
  logic [3:0] req_m;
  logic [3:0] words_m [4];
  int         ptr_m = 3;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_i  = req_m;
    bus.data_i = {words_m[3], words_m[2], words_m[1], words_m[0]};
  endtask

  task automatic push_frame(input int w);
    exp_t       e;
    logic [4:0] fr;
    fr = {1'b0, words_m[w]};
`ifdef SERIAL_PARITY_EN
    fr[4] = ^words_m[w];
`endif
    for (int b = 0; b < FL; b++) begin
      e.bit_v = fr[b];
      e.src   = 2'(w);
      e.last  = (b == FL - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic cycle();
    exp_t       e;
    logic [3:0] eg;
    int         w;
    int         c;
    logic       open;
    logic       had;
    #1;
    if (rst) begin
      chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
      chk("rst_valid", 32'(bus.valid_o), 32'd0);
      chk("rst_empty", 32'(bus.empty_o), 32'd1);
      chk("rst_serial", 32'(bus.serial_o), 32'd0);
      chk("rst_last", 32'(bus.last_o), 32'd0);
      chk("rst_src", 32'(bus.src_o), 32'd0);
      exp_q.delete();
      ptr_m = 3;
    end else begin
      had = (exp_q.size() != 0);
      chk("valid", 32'(bus.valid_o), 32'(had));
      chk("empty", 32'(bus.empty_o), 32'(!had));
      if (had) begin
        e = exp_q[0];
        chk("serial", 32'(bus.serial_o), 32'(e.bit_v));
        chk("src", 32'(bus.src_o), 32'(e.src));
        chk("last", 32'(bus.last_o), 32'(e.last));
        bit_log.push_back(bus.serial_o);
      end else begin
        chk("idle_serial", 32'(bus.serial_o), 32'd0);
        chk("idle_last", 32'(bus.last_o), 32'd0);
      end
      open = !had || exp_q[0].last;
      eg = 4'b0000;
      w  = -1;
      if (open) begin
        for (int i = 1; i <= 4; i++) begin
          c = (ptr_m + i) % 4;
          if (w < 0 && req_m[2'(c)]) w = c;
        end
      end
      if (w >= 0) eg[2'(w)] = 1'b1;
      chk("gnt", 32'(bus.gnt_o), 32'(eg));
      if (w >= 0) begin
        gnt_log.push_back(w);
        ptr_m = w;
        push_frame(w);
      end
      if (had) void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    bit_log.delete();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic chk_gnts(input string tag, input logic [11:0] seq, input int n);
    logic [11:0] s;
    s = seq;
    chk({tag, "_count"}, 32'(gnt_log.size()), 32'(n));
    if (gnt_log.size() >= n) begin
      for (int k = 0; k < n; k++) chk(tag, 32'(gnt_log[k]), 32'(s[k*3 +: 3]));
    end
  endtask

  initial begin
    logic [4:0] pat;

    // Reset held three cycles with every requester asking.
    rst = 1'b1;
    req_m = 4'hF;
    words_m[0] = 4'h1; words_m[1] = 4'h2; words_m[2] = 4'h4; words_m[3] = 4'h8;
    drive();
    @(negedge clk);
    repeat (3) cycle();

    // All requests held: fair order 0,1,2,3,0 with back-to-back frames.
    rst = 1'b0;
    clear_logs();
    for (int n = 0; n < 40 && gnt_log.size() < 5; n++) cycle();
    req_m = 4'h0;
    words_m[0] = 4'hF; words_m[1] = 4'hF; words_m[2] = 4'hF; words_m[3] = 4'hF;
    drive();
    repeat (FL + 2) cycle();
    chk_gnts("t_fair", {3'd0, 3'd3, 3'd2, 3'd1, 3'd0}, 5);
    if (bit_log.size() >= 4 * FL) begin
      for (int k = 0; k < 4; k++) chk("t_fair_onehot_bit", 32'(bit_log[k*FL + k]), 32'd1);
    end else begin
      chk("t_fair_bits", 32'(bit_log.size()), 32'(5 * FL));
    end

    // Single requester 0 with word A; data changed after the grant must not leak in.
    reset_pulse();
    req_m = 4'b0001;
    words_m[0] = 4'hA;
    drive();
    cycle();
    req_m = 4'b0000;
    words_m[0] = 4'h5;
    drive();
    repeat (FL + 2) cycle();
    chk_gnts("t_single", 12'd0, 1);
    pat = 5'b01010;
    chk("t_single_nbits", 32'(bit_log.size()), 32'(FL));
    if (bit_log.size() >= FL) begin
      for (int k = 0; k < FL; k++) chk("t_single_bit", 32'(bit_log[k]), 32'(pat[k]));
    end

    // After serving requester 3, requests 0 and 2 are served as 0 then 2.
    reset_pulse();
    req_m = 4'b1000;
    words_m[3] = 4'hC;
    drive();
    cycle();
    req_m = 4'b0101;
    words_m[0] = 4'h3;
    words_m[2] = 4'h6;
    drive();
    for (int n = 0; n < 30 && gnt_log.size() < 3; n++) cycle();
    req_m = 4'b0000;
    drive();
    repeat (FL + 2) cycle();
    chk_gnts("t_wrap", {3'd2, 3'd0, 3'd3}, 3);

    // Reset in the middle of a frame from requester 1.
    reset_pulse();
    req_m = 4'b0010;
    words_m[1] = 4'h9;
    drive();
    cycle();
    req_m = 4'b0000;
    drive();
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("t_abort_valid", 32'(bus.valid_o), 32'd0);
    chk("t_abort_empty", 32'(bus.empty_o), 32'd1);
    cycle();
    rst = 1'b0;
    clear_logs();
    req_m = 4'b0011;
    words_m[0] = 4'h6;
    drive();
    cycle();
    req_m = 4'b0000;
    drive();
    repeat (FL + 2) cycle();
    chk_gnts("t_abort_regrant", 12'd0, 1);

`ifdef SERIAL_PARITY_EN
    // Parity frames: 7 -> 1,1,1,0,1 and 3 -> parity bit 0.
    reset_pulse();
    req_m = 4'b0001;
    words_m[0] = 4'h7;
    drive();
    cycle();
    req_m = 4'b0000;
    drive();
    repeat (FL + 2) cycle();
    pat = 5'b10111;
    chk("t_par7_nbits", 32'(bit_log.size()), 32'd5);
    if (bit_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("t_par7_bit", 32'(bit_log[k]), 32'(pat[k]));
    end
    clear_logs();
    req_m = 4'b0001;
    words_m[0] = 4'h3;
    drive();
    cycle();
    req_m = 4'b0000;
    drive();
    repeat (FL + 2) cycle();
    chk("t_par3_nbits", 32'(bit_log.size()), 32'd5);
    if (bit_log.size() >= 5) chk("t_par3_parity", 32'(bit_log[4]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_rr_scheduler.md
Name: serial_rr_scheduler

Overview:
- Round-robin scheduler that shares one parallel-to-serial shift engine between NUM_REQ requesters.
- Each requester presents a DATA_W-bit word with a req/gnt handshake.
- The block arbitrates, captures the winner's word, and shifts it out LSB-first with valid, source-id and last-bit framing.
- Sits between word producers and a single-wire serial link.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 4, word width in bits (>=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request; word valid while high.
- data_i  input  NUM_REQ*DATA_W  packed words; requester k at [k*DATA_W +: DATA_W].
- gnt_o  output  NUM_REQ  one-hot grant; word captured on the edge where req_i[k] & gnt_o[k].
- serial_o  output  1  current serial bit.
- valid_o  output  1  serial_o carries a frame bit.
- src_o  output  $clog2(NUM_REQ)  index of requester owning the current frame.
- last_o  output  1  final bit of the frame.
- empty_o  output  1  no frame in progress (engine idle).

Behaviour:
- Reset (async, immediate):
  - State = IDLE; shift register, bit counter, serial_o, valid_o, last_o, src_o = 0; empty_o = 1.
  - RR pointer = NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, SHIFT.
- Grant window (gnt_o combinational):
  - Open when state==IDLE, or state==SHIFT and the last frame bit is on the output.
  - Outside the window gnt_o = 0.
  - Inside the window gnt_o is one-hot to the first asserted req_i, searching from pointer+1 upward with wrap-around; 0 if no requests.
- Capture edge: on an edge with a grant active:
  - shift register <= winner's word; src_o <= winner; pointer <= winner; counter <= 0; state <= SHIFT.
- SHIFT:
  - valid_o = 1, serial_o = shift register bit 0; register shifts right by one each cycle.
  - Frame length FRAME_LEN = DATA_W (DATA_W+1 with the optional feature).
  - last_o = 1 on bit FRAME_LEN-1.
  - After the last bit: go to SHIFT if a grant occurred in that cycle (back-to-back, no gap), else IDLE.
- Outputs in IDLE: valid_o = 0, last_o = 0, serial_o = 0, empty_o = 1. empty_o = 0 throughout SHIFT.
- Latency: word captured at edge N; its first bit is valid in the cycle after edge N.
- Requester rules: after a grant, a requester may hold req_i for its next word. data_i is sampled only at its capture edge.
- Simultaneous requests: exactly one grant per window; the others wait.
- Fairness: with all requests held, requesters are served 0,1,…,NUM_REQ-1,0,…
- Requests dropped before a grant window are simply not served. No grant is ever issued to a deasserted req_i.
- Reset mid-frame: the frame is aborted with no resume, and arbitration restarts from the reset pointer.

Optional Feature:
- Macro SERIAL_PARITY_EN.
- Defined:
  - Every frame appends one even-parity bit (XOR of the captured word) after the data bits.
  - FRAME_LEN = DATA_W+1; last_o is asserted on the parity bit.
  - The back-to-back grant window moves to the parity cycle.
- Undefined:
  - FRAME_LEN = DATA_W, no parity logic is present, and last_o is asserted on data bit DATA_W-1.

Test Plan:
- Reset held 3 cycles with req_i=4'hF: gnt_o=0, valid_o=0, empty_o=1, serial_o=0. Release: first grant goes to requester 0.
- req_i=4'b0001, word0=4'hA:
  - gnt_o=4'b0001 for one cycle.
  - Next 4 cycles: serial_o=0,1,0,1, valid_o=1, src_o=0, last_o only on the 4th bit.
  - Then empty_o=1, valid_o=0.
- req_i=4'hF held, words 4'h1,4'h2,4'h4,4'h8:
  - Grants in order 0,1,2,3,0.
  - valid_o high 16+ consecutive cycles with no gap; src_o steps 0→1→2→3.
  - Bit 0 of each frame reflects its word.
- After a grant to requester 3, req_i=4'b0101: requester 0 is granted before requester 2, then requester 2.
- Frame from requester 1 with 2 bits shifted, reset pulsed:
  - valid_o=0 and empty_o=1 immediately (before the next edge).
  - After release with req_i=4'b0011, the next grant is requester 0.
- SERIAL_PARITY_EN defined, word 4'h7: serial_o=1,1,1,0,1, last_o on the 5th bit. Word 4'h3 gives parity bit 0.
